router_ctrl: RTL and testbench

Input-side packet controller for the 1x3 router. It accepts a byte stream from the source under a valid/busy handshake and decodes the header address. It steers header, payload and parity bytes into one of three output FIFOs with `lfd_state` marking the header, and checks packet parity. It also owns per-port valid/soft-reset timeout logic for the downstream readers.

---
 rtl/router_ctrl_if.sv | 19 +
 rtl/router_ctrl.sv | 164 ++++++++++++++++
 tb/tb_router_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/router_ctrl_if.sv
// Source-side byte handshake for the 1x3 router.
// The source drives pkt_valid/data_in and holds them while busy is high.
interface router_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       busy;

  modport master (
    output pkt_valid,
    output data_in,
    input  busy
  );

  modport slave (
    input  pkt_valid,
    input  data_in,
    output busy
  );
endinterface

// File: rtl/router_ctrl.sv
// Input-side packet controller for the 1x3 router: header decode,
// FIFO steering, parity check and per-port read timeout.
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic         clk,
  input  logic         rst,
  router_ctrl_if.slave src,
  input  logic [2:0]   fifo_full,
  input  logic [2:0]   fifo_empty,
  input  logic [2:0]   read_enb,
  output logic [7:0]   data_out,
  output logic [2:0]   wr_en,
  output logic         lfd_state,
  output logic         err,
  output logic [2:0]   vld_out,
  output logic [2:0]   soft_rst
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PARITY,
    DROP
  } state_t;

  state_t     state;
  logic [1:0] addr_q;
  logic [6:0] rem;
  logic [7:0] par_q;
  logic [5:0] to_cnt [3];

  logic [1:0] hdr_addr;
  logic [5:0] hdr_len;
  logic [3:0] empty_x;
  logic [3:0] full_x;
  logic [3:0] fire_x;
  logic [3:0] wr_x;
  logic [2:0] to_fire;
  logic       accept;
  logic       abort;

  assign hdr_addr = src.data_in[1:0];
  assign hdr_len  = src.data_in[7:2];
  assign data_out = src.data_in;
  assign vld_out  = ~fifo_empty;

  // Padded to 4 entries so address 3 indexes safely.
  assign empty_x = {1'b1, fifo_empty};
  assign full_x  = {1'b1, fifo_full};
  assign fire_x  = {1'b0, to_fire};

  always_comb begin
    src.busy = 1'b0;
    unique case (state)
      IDLE:
        src.busy = src.pkt_valid
                && (hdr_addr != 2'd3)
                && !empty_x[hdr_addr];
      LOAD,
      PARITY:
        src.busy = full_x[addr_q];
      DROP:
        src.busy = 1'b0;
      default:
        src.busy = 1'b0;
    endcase
  end

  assign accept = src.pkt_valid && !src.busy;

  always_comb begin
    wr_x      = '0;
    lfd_state = 1'b0;
    if (rst && accept) begin
      unique case (state)
        IDLE:
          if (hdr_addr != 2'd3
              && !full_x[hdr_addr]) begin
            wr_x[hdr_addr] = 1'b1;
            lfd_state      = 1'b1;
          end
        LOAD,
        PARITY:
          if (!full_x[addr_q])
            wr_x[addr_q] = 1'b1;
        default: ;
      endcase
    end
    wr_en = wr_x[2:0];
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      to_fire[i] = vld_out[i] && !read_enb[i]
                && (to_cnt[i] == 6'(TIMEOUT - 1));
  end

  assign abort = (state == LOAD || state == PARITY)
              && fire_x[addr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      rem      <= '0;
      par_q    <= '0;
      err      <= 1'b0;
      soft_rst <= '0;
      for (int i = 0; i < 3; i++)
        to_cnt[i] <= '0;
    end else begin
      err <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        soft_rst[i] <= to_fire[i];
        if (vld_out[i] && !read_enb[i] && !to_fire[i])
          to_cnt[i] <= to_cnt[i] + 6'd1;
        else
          to_cnt[i] <= '0;
      end
      unique case (state)
        IDLE:
          if (accept) begin
            addr_q <= hdr_addr;
            rem    <= {1'b0, hdr_len} + 7'd1;
            par_q  <= src.data_in;
            if (hdr_addr == 2'd3)
              state <= DROP;
            else if (hdr_len != 6'd0)
              state <= LOAD;
            else
              state <= PARITY;
          end
        LOAD: begin
          if (accept) begin
            par_q <= par_q ^ src.data_in;
            rem   <= rem - 7'd1;
            if (rem == 7'd2)
              state <= PARITY;
          end
          if (abort)
            state <= DROP;
        end
        PARITY:
          if (accept) begin
            rem   <= rem - 7'd1;
            state <= IDLE;
            err   <= (src.data_in != par_q) && !abort;
          end else if (abort) begin
            state <= DROP;
          end
        DROP:
          if (accept) begin
            rem <= rem - 7'd1;
            if (rem == 7'd1)
              state <= IDLE;
          end
        default:
          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl.
// Expected values are hand-computed from the packet format.
module tb_router_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [7:0] data_out;
  logic [2:0] wr_en;
  logic       lfd_state;
  logic       err;
  logic [2:0] vld_out;
  logic [2:0] soft_rst;

  int n_chk;
  int n_fail;

  router_ctrl_if rif ();

  router_ctrl #(.TIMEOUT(30)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (rif.slave),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .wr_en      (wr_en),
    .lfd_state  (lfd_state),
    .err        (err),
    .vld_out    (vld_out),
    .soft_rst   (soft_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag,
                      input logic [7:0] b,
                      input logic [2:0] ew,
                      input logic el);
    rif.pkt_valid = 1'b1;
    rif.data_in   = b;
    #2;
    chk({tag, "_busy"}, 32'(rif.busy), 32'h0);
    chk({tag, "_wr"}, 32'(wr_en), 32'(ew));
    chk({tag, "_lfd"}, 32'(lfd_state), 32'(el));
    chk({tag, "_dout"}, 32'(data_out), 32'(b));
    step();
  endtask

  task automatic hold(input string tag,
                      input logic [7:0] b);
    rif.pkt_valid = 1'b1;
    rif.data_in   = b;
    #2;
    chk({tag, "_busy"}, 32'(rif.busy), 32'h1);
    chk({tag, "_wr"}, 32'(wr_en), 32'h0);
    step();
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rst            = 1'b0;
    rif.pkt_valid  = 1'b1;
    rif.data_in    = 8'h0D;
    fifo_full      = 3'b000;
    fifo_empty     = 3'b111;
    read_enb       = 3'b000;

    // Reset with a valid header presented
    #12;
    chk("rst_wr", 32'(wr_en), 32'h0);
    chk("rst_lfd", 32'(lfd_state), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_srst", 32'(soft_rst), 32'h0);
    chk("rst_busy", 32'(rif.busy), 32'h0);
    chk("rst_dout", 32'(data_out), 32'h0D);
    chk("rst_vld", 32'(vld_out), 32'h0);
    step();
    rst           = 1'b1;
    rif.pkt_valid = 1'b0;
    step();

    // Good packet to port 1
    send("p1_h", 8'h0D, 3'b010, 1'b1);
    send("p1_d0", 8'h11, 3'b010, 1'b0);
    send("p1_d1", 8'h22, 3'b010, 1'b0);
    send("p1_d2", 8'h33, 3'b010, 1'b0);
    chk("p1_err_mid", 32'(err), 32'h0);
    send("p1_par", 8'h0D, 3'b010, 1'b0);
    rif.pkt_valid = 1'b0;
    chk("p1_err", 32'(err), 32'h0);

    // Bad parity, back-to-back
    send("p2_h", 8'h0D, 3'b010, 1'b1);
    send("p2_d0", 8'h11, 3'b010, 1'b0);
    send("p2_d1", 8'h22, 3'b010, 1'b0);
    send("p2_d2", 8'h33, 3'b010, 1'b0);
    send("p2_par", 8'h00, 3'b010, 1'b0);
    rif.pkt_valid = 1'b0;
    chk("p2_err", 32'(err), 32'h1);
    step();
    chk("p2_err_end", 32'(err), 32'h0);

    // Header waits for FIFO 2 to drain
    fifo_empty = 3'b011;
    hold("p3_wait0", 8'h0A);
    hold("p3_wait1", 8'h0A);
    fifo_empty = 3'b111;
    send("p3_h", 8'h0A, 3'b100, 1'b1);
    send("p3_d0", 8'h01, 3'b100, 1'b0);
    send("p3_d1", 8'h02, 3'b100, 1'b0);
    send("p3_par", 8'h09, 3'b100, 1'b0);
    rif.pkt_valid = 1'b0;
    chk("p3_err", 32'(err), 32'h0);

    // FIFO 0 full stall mid-packet
    send("p4_h", 8'h0C, 3'b001, 1'b1);
    send("p4_d0", 8'hA1, 3'b001, 1'b0);
    send("p4_d1", 8'hB2, 3'b001, 1'b0);
    fifo_full = 3'b001;
    hold("p4_full0", 8'hC3);
    hold("p4_full1", 8'hC3);
    hold("p4_full2", 8'hC3);
    fifo_full = 3'b000;
    send("p4_d2", 8'hC3, 3'b001, 1'b0);
    send("p4_par", 8'hDC, 3'b001, 1'b0);
    rif.pkt_valid = 1'b0;
    chk("p4_err", 32'(err), 32'h0);

    // Invalid address dropped, then a zero-length packet
    send("p5_h", 8'h07, 3'b000, 1'b0);
    send("p5_d0", 8'h55, 3'b000, 1'b0);
    send("p5_d1", 8'h66, 3'b000, 1'b0);
    send("p6_h", 8'h01, 3'b010, 1'b1);
    send("p6_par", 8'h01, 3'b010, 1'b0);
    rif.pkt_valid = 1'b0;
    chk("p6_err", 32'(err), 32'h0);

    // Port 0 read timeout
    fifo_empty = 3'b110;
    #2;
    chk("to_vld", 32'(vld_out), 32'h1);
    repeat (29) step();
    chk("to_pre", 32'(soft_rst), 32'h0);
    step();
    chk("to_fire", 32'(soft_rst), 32'h1);
    step();
    chk("to_pulse", 32'(soft_rst), 32'h0);
    fifo_empty = 3'b111;
    step();

    // A read in cycle 29 restarts the count
    fifo_empty = 3'b110;
    repeat (28) step();
    read_enb = 3'b001;
    step();
    read_enb = 3'b000;
    step();
    chk("to_rd30", 32'(soft_rst), 32'h0);
    repeat (28) step();
    chk("to_rd58", 32'(soft_rst), 32'h0);
    step();
    chk("to_rd59", 32'(soft_rst), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
